// File: rtl/core_led_driver.sv
// LED pin driver: global PWM dimming plus blink-on-change flagging of software LED updates.
// Optional heartbeat on led[7] when CORE_LED_HEARTBEAT_EN is defined.
module core_led_driver #(
   parameter int unsigned PRESC_DIV   = 50000,
   parameter int unsigned BLINK_TICKS = 8,
   parameter int unsigned PWM_W       = 8,
   parameter int unsigned BRIGHTNESS  = 255,
   parameter logic [7:0]  RESET_CMD   = 8'h33,
   parameter int unsigned HB_TICKS    = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] led_cmd,
   output logic [7:0] led,
   output logic       flashing
);

   localparam int unsigned PSW     = $clog2(PRESC_DIV);
   localparam int unsigned BCW     = $clog2(BLINK_TICKS + 1);
   localparam int unsigned PWM_MAX = (1 << PWM_W) - 1;

   typedef enum logic {IDLE, FLASH} state_e;

   state_e           state_q;
   logic [7:0]       cmd_q;
   logic [7:0]       mask_q;
   logic [7:0]       led_q;
   logic [7:0]       led_d;
   logic [7:0]       chg;
   logic             flashing_q;
   logic             phase_q;
   logic [PSW-1:0]   presc_q;
   logic [PWM_W-1:0] pwm_cnt_q;
   logic [BCW-1:0]   blink_q;
   logic             tick;
   logic             pwm_on;

   assign tick   = (presc_q == PSW'(PRESC_DIV - 1));
   assign pwm_on = (BRIGHTNESS == PWM_MAX) || (32'(pwm_cnt_q) < BRIGHTNESS);

`ifdef CORE_LED_HEARTBEAT_EN
   localparam int unsigned HBW      = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;
   localparam logic [7:0]  CHG_MASK = 8'h7F;

   logic [HBW-1:0] hb_cnt_q;
   logic           hb_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hb_cnt_q <= '0;
         hb_q     <= 1'b0;
      end else if (tick) begin
         if (hb_cnt_q == HBW'(HB_TICKS - 1)) begin
            hb_cnt_q <= '0;
            hb_q     <= ~hb_q;
         end else begin
            hb_cnt_q <= hb_cnt_q + 1'b1;
         end
      end
   end
`else
   localparam logic [7:0]  CHG_MASK = 8'hFF;
`endif

   always_comb begin
      chg   = (cmd_q ^ led_cmd) & CHG_MASK;
      led_d = cmd_q;
      if (state_q == FLASH) begin
         led_d = (cmd_q & ~mask_q) | (mask_q & {8{phase_q}});
      end
`ifdef CORE_LED_HEARTBEAT_EN
      led_d[7] = hb_q;
`endif
      led_d = led_d & {8{pwm_on}};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_q     <= RESET_CMD;
         presc_q   <= '0;
         pwm_cnt_q <= '0;
      end else begin
         cmd_q     <= led_cmd;
         presc_q   <= tick ? '0 : presc_q + 1'b1;
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
      end
   end

   // A fresh change always wins over the tick, so the blink window restarts from the last change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         mask_q     <= '0;
         blink_q    <= '0;
         phase_q    <= 1'b0;
         led_q      <= '0;
         flashing_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (chg != '0) begin
                  mask_q  <= chg;
                  blink_q <= BCW'(BLINK_TICKS);
                  phase_q <= 1'b1;
                  state_q <= FLASH;
               end
            end
            FLASH: begin
               if (chg != '0) begin
                  mask_q  <= mask_q | chg;
                  blink_q <= BCW'(BLINK_TICKS);
                  phase_q <= 1'b1;
               end else if (tick) begin
                  if (blink_q == BCW'(1)) begin
                     mask_q  <= '0;
                     phase_q <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     blink_q <= blink_q - 1'b1;
                     phase_q <= ~phase_q;
                  end
               end
            end
         endcase
         led_q      <= led_d;
         flashing_q <= (state_q == FLASH);
      end
   end

   assign led      = led_q;
   assign flashing = flashing_q;

endmodule

// File: doc/core_led_driver.md
Name: core_led_driver

Overview:
- Downstream consumer of the 8-bit LED PIO output (`out_port`) in the inverter control core. Drives the 8 board LED pins.
- Applies global PWM dimming to the LEDs.
- Flags software-initiated LED changes by blinking the changed LEDs for a fixed number of prescaler ticks.
- Single clock domain shared with the PIO.

Parameters:
- PRESC_DIV, 50000, clk cycles per blink tick (>=2).
- BLINK_TICKS, 8, number of ticks a changed LED blinks (>=1).
- PWM_W, 8, width of the PWM counter.
- BRIGHTNESS, 255, PWM compare value. 0 = always off; 2^PWM_W-1 = always on.
- RESET_CMD, 8'h33, reset value of the internal command register. Matches the PIO reset value so no spurious flash occurs after reset.
- HB_TICKS, 16, ticks per heartbeat half-period (only used with the optional feature).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- led_cmd  input  8  LED command, connected to PIO `out_port`
- led  output  8  LED pins, active high, registered
- flashing  output  1  high while the FSM is in FLASH, registered

Behaviour:
- Reset (async, reset_n=0):
  - led=0, flashing=0, cmd_q=RESET_CMD.
  - mask=0, prescaler=0, pwm_cnt=0, state=IDLE, blink_cnt=0, phase=0.
- cmd_q <= led_cmd every cycle.
- chg = cmd_q ^ led_cmd (combinational).
- Prescaler:
  - Free-running counter 0..PRESC_DIV-1, wraps to 0.
  - tick = 1-cycle pulse when count == PRESC_DIV-1.
- PWM:
  - pwm_cnt is free-running, wraps 2^PWM_W-1 -> 0.
  - pwm_on = (BRIGHTNESS == 2^PWM_W-1) | (pwm_cnt < BRIGHTNESS), unsigned compare.
- FSM IDLE:
  - If chg != 0: mask <= chg, blink_cnt <= BLINK_TICKS, phase <= 1, go to FLASH.
- FSM FLASH:
  - New chg != 0 (any cycle, including a tick cycle): mask <= mask | chg, blink_cnt <= BLINK_TICKS, phase <= 1. This takes priority over tick handling.
  - Else on tick with blink_cnt == 1: mask <= 0, phase <= 0, go to IDLE.
  - Else on tick: blink_cnt <= blink_cnt-1, phase <= ~phase.
- Output register (each cycle):
  - In IDLE: led[i] <= cmd_q[i] & pwm_on.
  - In FLASH: led[i] <= (mask[i] ? phase : cmd_q[i]) & pwm_on.
  - flashing <= (state == FLASH).
- Latency:
  - A led_cmd change sampled at edge n updates cmd_q/state/mask at edge n.
  - The led pins reflect it at edge n+1 (2 edges from input to pin).
- Boundaries:
  - A bit that toggles back during FLASH stays in mask until FLASH ends. It then shows its final cmd_q value.
  - FLASH duration is exactly BLINK_TICKS ticks after the last change; the first tick may arrive 1..PRESC_DIV cycles after entry.
  - Reset asserted mid-FLASH aborts immediately to reset values.
  - No change while IDLE: mask stays 0; the prescaler still runs.

Optional Feature:
- Macro: CORE_LED_HEARTBEAT_EN.
- Defined:
  - A heartbeat register toggles every HB_TICKS ticks, with its own tick counter reset to 0.
  - led[7] <= heartbeat & pwm_on, overriding command and flash for bit 7.
  - led_cmd[7] changes are excluded from chg (no FLASH entry from bit 7).
  - Heartbeat resets to 0.
- Undefined:
  - No heartbeat logic.
  - Bit 7 behaves like bits 0..6.

Test Plan (PRESC_DIV=4, BLINK_TICKS=3, PWM_W=4, BRIGHTNESS=15, macro off unless noted):
- Reset with led_cmd=8'h33 held, run 50 cycles -> led=8'h33 from second edge after release; flashing stays 0.
- From steady 8'h33, drive led_cmd=8'h32 for 1+ cycle -> flashing=1 one edge later. led[0] blinks 1,0,1 across the 3 ticks; other bits stay at cmd. flashing=0 and led=8'h32 after the 3rd tick.
- During FLASH on bit 0, change led_cmd to 8'h22 -> mask becomes 8'h11, blink_cnt reloads to 3, phase=1. FLASH ends 3 ticks after that change; final led=8'h22.
- BRIGHTNESS=4, led_cmd=8'hFF steady -> each led bit high exactly 4 of every 16 cycles. BRIGHTNESS=0 -> led=0 constantly.
- Assert reset_n=0 mid-FLASH -> led=0 and flashing=0 asynchronously. After release with led_cmd=8'h33 -> no flash.
- CORE_LED_HEARTBEAT_EN, HB_TICKS=2 -> led[7] toggles every 8 cycles. Toggling led_cmd[7] does not raise flashing.
